// File: rtl/shift_engine_pkg.sv
// Shared types for the shift engine: operation modes and controller states.
package shift_pkg;

    typedef enum logic [2:0] {
        LOAD = 3'd0,
        SIR  = 3'd1,
        LSL  = 3'd2,
        LSR  = 3'd3,
        ASR  = 3'd4,
        ROL  = 3'd5,
        ROR  = 3'd6,
        SIL  = 3'd7
    } mode_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/shift_engine_if.sv
// Request/status bundle of the shift engine; carry exists only with SHIFT_CARRY_EN.
interface shift_engine_if #(
    parameter int WIDTH = 8,
    parameter int AMT_W = $clog2(WIDTH) + 1
);
    logic             start;
    logic [2:0]       mode;
    logic [AMT_W-1:0] amt;
    logic [WIDTH-1:0] din;
    logic             ser_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] dout;
`ifdef SHIFT_CARRY_EN
    logic             carry;

    modport master (output start, mode, amt, din, ser_in,
                    input  busy, done, dout, carry);
    modport slave  (input  start, mode, amt, din, ser_in,
                    output busy, done, dout, carry);
`else
    modport master (output start, mode, amt, din, ser_in,
                    input  busy, done, dout);
    modport slave  (input  start, mode, amt, din, ser_in,
                    output busy, done, dout);
`endif
endinterface

// File: rtl/shift_engine_step.sv
// Combinational single step of the shift engine: shifts a word by 0..STEP positions.
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int STEP  = 1,
    parameter int KW    = $clog2(STEP + 1)
) (
    input  logic [WIDTH-1:0] i_word,
    input  mode_t            i_mode,
    input  logic [KW-1:0]    i_k,
    input  logic             i_ser_in,
    output logic [WIDTH-1:0] o_word,
    output logic             o_bit
);

    // A k-position shift is k chained 1-bit shifts; o_bit keeps the last bit to leave.
    always_comb begin
        o_word = i_word;
        o_bit  = 1'b0;
        for (int unsigned i = 0; i < STEP; i++) begin
            if (KW'(i) < i_k) begin
                case (i_mode)
                    SIR: begin o_bit = o_word[0];       o_word = {i_ser_in, o_word[WIDTH-1:1]}; end
                    LSL: begin o_bit = o_word[WIDTH-1]; o_word = {o_word[WIDTH-2:0], 1'b0}; end
                    LSR: begin o_bit = o_word[0];       o_word = {1'b0, o_word[WIDTH-1:1]}; end
                    ASR: begin o_bit = o_word[0];       o_word = {o_word[WIDTH-1], o_word[WIDTH-1:1]}; end
                    ROL: begin o_bit = o_word[WIDTH-1]; o_word = {o_word[WIDTH-2:0], o_word[WIDTH-1]}; end
                    ROR: begin o_bit = o_word[0];       o_word = {o_word[0], o_word[WIDTH-1:1]}; end
                    SIL: begin o_bit = o_word[WIDTH-1]; o_word = {o_word[WIDTH-2:0], i_ser_in}; end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/shift_engine.sv
// Multi-cycle universal shift engine, up to STEP positions per clock.
// Optional carry output is enabled by defining SHIFT_CARRY_EN.
module shift_engine
    import shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int STEP  = 1,
    localparam int AMT_W = $clog2(WIDTH) + 1
) (
    input  logic           clk,
    input  logic           rst_n,
    shift_engine_if.slave  bus
);

    localparam int KW = $clog2(STEP + 1);

    state_t           r_state;
    mode_t            r_mode;
    logic [AMT_W-1:0] r_rem;
    logic [WIDTH-1:0] r_dout;

    logic             w_accept;
    logic [AMT_W-1:0] w_amt_clamp;
    logic [AMT_W-1:0] w_k_full;
    logic [WIDTH-1:0] w_next;
    logic             w_bit;

    assign w_accept    = bus.start && (r_state != RUN);
    assign w_amt_clamp = (bus.amt > AMT_W'(WIDTH)) ? AMT_W'(WIDTH) : bus.amt;
    assign w_k_full    = (r_rem > AMT_W'(STEP)) ? AMT_W'(STEP) : r_rem;

    shift_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP),
        .KW    (KW)
    ) u_step (
        .i_word   (r_dout),
        .i_mode   (r_mode),
        .i_k      (KW'(w_k_full)),
        .i_ser_in (bus.ser_in),
        .o_word   (w_next),
`ifdef SHIFT_CARRY_EN
        .o_bit    (w_bit)
`else
        .o_bit    ()
`endif
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_mode  <= LOAD;
            r_rem   <= '0;
            r_dout  <= '0;
        end else if (w_accept) begin
            r_dout  <= bus.din;
            r_mode  <= mode_t'(bus.mode);
            r_rem   <= w_amt_clamp;
            r_state <= (w_amt_clamp == '0 || mode_t'(bus.mode) == LOAD) ? DONE : RUN;
        end else begin
            case (r_state)
                RUN: begin
                    r_dout <= w_next;
                    r_rem  <= r_rem - w_k_full;
                    if (r_rem == w_k_full)
                        r_state <= DONE;
                end
                DONE:    r_state <= IDLE;
                default: ;
            endcase
        end
    end

`ifdef SHIFT_CARRY_EN
    logic r_carry;

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_carry <= 1'b0;
        else if (w_accept)
            r_carry <= 1'b0;
        else if (r_state == RUN)
            r_carry <= w_bit;
    end

    assign bus.carry = r_carry;
`else
    assign w_bit = 1'b0;
`endif

    assign bus.busy = (r_state == RUN);
    assign bus.done = (r_state == DONE);
    assign bus.dout = r_dout;

endmodule

// File: tb/tb_shift_engine.sv
// Directed self-checking bench for shift_engine (STEP=1 and STEP=3 instances).
module tb_shift_engine;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    shift_engine_if #(.WIDTH(8)) bus1 ();
    shift_engine_if #(.WIDTH(8)) bus3 ();

    shift_engine #(.WIDTH(8), .STEP(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
    shift_engine #(.WIDTH(8), .STEP(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3.slave));

    int n_assert = 0;
    int n_fail   = 0;
    int lat;
    int nb;
    int ndone;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start1(input logic [2:0] m, input logic [3:0] a, input logic [7:0] d);
        bus1.start = 1'b1;
        bus1.mode  = m;
        bus1.amt   = a;
        bus1.din   = d;
        @(posedge clk); #1;
        bus1.start = 1'b0;
    endtask

    // Returns the cycle index (1 = first cycle after the accepting edge) where done is seen.
    task automatic wait_done1(input int lat0, output int l, output int b);
        l = lat0;
        b = 0;
        while (bus1.done !== 1'b1 && l < 40) begin
            if (bus1.busy === 1'b1) b++;
            @(posedge clk); #1;
            l++;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        bus1.start = 1'b0; bus1.mode = '0; bus1.amt = '0; bus1.din = '0; bus1.ser_in = 1'b0;
        bus3.start = 1'b0; bus3.mode = '0; bus3.amt = '0; bus3.din = '0; bus3.ser_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_dout",  32'(bus1.dout), 32'h00);
        chk("reset_busy",  32'(bus1.busy), 32'h0);
        chk("reset_done",  32'(bus1.done), 32'h0);
        chk("reset_dout3", 32'(bus3.dout), 32'h00);
`ifdef SHIFT_CARRY_EN
        chk("reset_carry", 32'(bus1.carry), 32'h0);
`endif
        rst_n = 1'b1;
        @(posedge clk); #1;

        // LSL 0x96 by 3
        start1(3'd2, 4'd3, 8'h96);
        wait_done1(1, lat, nb);
        chk("lsl_latency", 32'(lat), 32'd4);
        chk("lsl_dout",    32'(bus1.dout), 32'hB0);
`ifdef SHIFT_CARRY_EN
        chk("lsl_carry",   32'(bus1.carry), 32'h0);
`endif
        @(posedge clk); #1;
        chk("idle_done",   32'(bus1.done), 32'h0);
        chk("idle_hold",   32'(bus1.dout), 32'hB0);

        // ASR 0x90 by 2
        start1(3'd4, 4'd2, 8'h90);
        wait_done1(1, lat, nb);
        chk("asr_latency", 32'(lat), 32'd3);
        chk("asr_busy",    32'(nb), 32'd2);
        chk("asr_dout",    32'(bus1.dout), 32'hE4);
`ifdef SHIFT_CARRY_EN
        chk("asr_carry",   32'(bus1.carry), 32'h0);
`endif
        @(posedge clk); #1;

        // ROR 0x81 by 9, clamped to 8
        start1(3'd6, 4'd9, 8'h81);
        wait_done1(1, lat, nb);
        chk("ror_latency", 32'(lat), 32'd9);
        chk("ror_dout",    32'(bus1.dout), 32'h81);
`ifdef SHIFT_CARRY_EN
        chk("ror_carry",   32'(bus1.carry), 32'h1);
`endif
        @(posedge clk); #1;

        // STEP=3: LSR 0xFF by 7 in steps 3,3,1
        bus3.start = 1'b1; bus3.mode = 3'd3; bus3.amt = 4'd7; bus3.din = 8'hFF;
        @(posedge clk); #1;
        bus3.start = 1'b0;
        chk("s3_busy",  32'(bus3.busy), 32'h1);
        @(posedge clk); #1;
        chk("s3_step1", 32'(bus3.dout), 32'h1F);
        lat = 2;
        while (bus3.done !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("s3_latency", 32'(lat), 32'd4);
        chk("s3_dout",    32'(bus3.dout), 32'h01);
`ifdef SHIFT_CARRY_EN
        chk("s3_carry",   32'(bus3.carry), 32'h1);
`endif
        @(posedge clk); #1;

        // SIL with ser_in=1, ignored start in RUN, back-to-back LOAD in done cycle
        bus1.ser_in = 1'b1;
        start1(3'd7, 4'd4, 8'h00);
        bus1.start = 1'b1; bus1.mode = 3'd0; bus1.amt = 4'd0; bus1.din = 8'hAA;
        @(posedge clk); #1;
        bus1.start = 1'b0;
        chk("sil_ignore_dout", 32'(bus1.dout), 32'h01);
        chk("sil_ignore_busy", 32'(bus1.busy), 32'h1);
        wait_done1(2, lat, nb);
        chk("sil_latency", 32'(lat), 32'd5);
        chk("sil_dout",    32'(bus1.dout), 32'h0F);
        start1(3'd0, 4'd3, 8'h5A);
        chk("b2b_done", 32'(bus1.done), 32'h1);
        chk("b2b_dout", 32'(bus1.dout), 32'h5A);
        chk("b2b_busy", 32'(bus1.busy), 32'h0);
        @(posedge clk); #1;
        chk("b2b_done_drop", 32'(bus1.done), 32'h0);

        // Reset during the 3rd RUN cycle of LSL 0xFF by 6; start held to show reset priority
        bus1.ser_in = 1'b0;
        start1(3'd2, 4'd6, 8'hFF);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_mid_busy_before", 32'(bus1.busy), 32'h1);
        rst_n = 1'b0;
        bus1.start = 1'b1; bus1.mode = 3'd2; bus1.amt = 4'd6; bus1.din = 8'hFF;
        @(posedge clk); #1;
        chk("rst_mid_dout", 32'(bus1.dout), 32'h00);
        chk("rst_mid_busy", 32'(bus1.busy), 32'h0);
        chk("rst_mid_done", 32'(bus1.done), 32'h0);
`ifdef SHIFT_CARRY_EN
        chk("rst_mid_carry", 32'(bus1.carry), 32'h0);
`endif
        bus1.start = 1'b0;
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (bus1.done === 1'b1 || bus1.busy === 1'b1) ndone++;
        end
        chk("rst_no_done", 32'(ndone), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_engine.md
# shift_engine

Parametrised multi-cycle universal shift engine, the next generation of our 4-bit universal shift register. It loads a WIDTH-bit operand and shifts it by a requested distance in one of eight modes, at up to STEP bit positions per clock. A start/busy/done handshake lets a controller or testbench sequencer drive it. It sits in the datapath wherever a variable-distance shift is needed and a full barrel shifter is too large.

## Interface
- WIDTH, 8, operand width in bits; minimum 2.
- STEP, 1, maximum bit positions shifted per clock; range 1..WIDTH.
- AMT_W, $clog2(WIDTH)+1, width of the shift-amount port (derived; not overridden).
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  request; sampled only when the engine is accepting (IDLE or DONE).
- mode  in  3  operation, sampled with start.
- amt  in  AMT_W  shift distance, sampled with start; values above WIDTH are clamped to WIDTH.
- din  in  WIDTH  operand, sampled with start.
- ser_in  in  1  serial fill bit for modes 1 and 7; sampled on every RUN edge.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse in DONE.
- dout  out  WIDTH  working register; always visible.
- carry  out  1  last bit shifted out; present only with SHIFT_CARRY_EN.

## Operation
Modes:
- 0 LOAD: no shift.
- 1 SIR: shift right; ser_in enters at the MSB.
- 2 LSL: zero fill at the LSB.
- 3 LSR: zero fill at the MSB.
- 4 ASR: the MSB is replicated.
- 5 ROL
- 6 ROR
- 7 SIL: shift left; ser_in enters at the LSB.

For modes 1 and 7, every fill position within one step takes the value of ser_in.

FSM states are IDLE, RUN and DONE.
- **Accepting start (IDLE or DONE, start=1):**
  - dout ← din, latch mode, rem ← min(amt, WIDTH).
  - If rem=0 or mode=LOAD, the next state is DONE.
  - Otherwise the next state is RUN.
- **RUN edge:**
  - Shift by k = min(STEP, rem), then rem ← rem−k.
  - When rem reaches 0, the next state is DONE.
- **DONE:**
  - Next state is IDLE unless a new start is accepted.
- **start while in RUN:** ignored, with no effect.
- **dout:** holds its value in IDLE until the next accepted start.
- **Reset:**
  - Values: dout=0, state IDLE, busy=0, done=0, carry=0, rem=0.
  - Reset in the middle of an operation aborts it; the next cycle shows the reset values.
  - rst_n has priority over start.

## Timing
- start accepted at edge E0.
- done is high during the cycle following edge E0 + ceil(rem/STEP).
- Latency from start to done:
  - ceil(rem/STEP)+1 cycles.
  - 1 cycle when rem=0 or mode=LOAD.
- busy is high from the cycle after E0 until the last RUN edge.
- Back-to-back operation: start asserted during the done cycle is accepted, with no idle gap.
- Rotate by WIDTH returns the original operand.
- LSL/LSR by WIDTH yields 0.
- ASR by WIDTH yields all sign bits.

## Configuration
- SHIFT_CARRY_EN defined:
  - The carry port and register exist.
  - carry is cleared on an accepted start.
  - On each RUN edge it takes the last bit to leave the word. For rotates, that is the bit that wrapped around.
  - carry holds its value through DONE and IDLE.
- SHIFT_CARRY_EN undefined:
  - No carry port and no carry logic.
  - All other behaviour is identical.

## Structure
- Package shift_pkg holds:
  - the mode enum: LOAD, SIR, LSL, LSR, ASR, ROL, ROR, SIL;
  - the state enum: IDLE, RUN, DONE.
- Sub-module shift_step is a combinational single step.
  - Inputs: word, mode, k (0..STEP), ser_in.
  - Outputs: next word and out-bit.
  - It is instantiated once.
- The top level holds the FSM, the rem counter and the registers.

## Test plan
All scenarios use WIDTH=8 and STEP=1 unless noted otherwise.
- LSL, din=8'h96, amt=3 → done 4 cycles after start, dout=8'hB0, carry=0.
- ASR, din=8'h90, amt=2 → dout=8'hE4, carry=0; busy high for exactly 2 cycles.
- ROR, din=8'h81, amt=9 (clamped to 8) → done after 9 cycles, dout=8'h81, carry=1.
- STEP=3, LSR, din=8'hFF, amt=7 → steps of 3,3,1, done 4 cycles after start, dout=8'h01, carry=1.
- SIL, din=0, amt=4, ser_in=1 → dout=8'h0F; a start pulse during RUN is ignored; a second start in the done cycle (LOAD, din=8'h5A) → dout=8'h5A, done on the next cycle.
- Reset mid-operation: LSL amt=6, rst_n low at the 3rd RUN cycle → next cycle dout=0, busy=0, done=0, carry=0, and no done pulse follows.
